// File: rtl/renkon_linebuf_pad_pkg.sv
// Shared widths for the renkon line buffer and its neighbours.
package renkon_linebuf_pad_pkg;
  localparam int DWIDTH = 16;  // pixel width
  localparam int LWIDTH = 16;  // line-length counter width used by the control block
endpackage

// File: rtl/renkon_linebuf_pad_if.sv
// Control-block to line-buffer bus: write/read selects, column address, pixel in, window out.
interface renkon_linebuf_pad_if
  import renkon_linebuf_pad_pkg::*;
#(
  parameter int MAXFIL = 3,
  parameter int MAXIMG = 32
);
  localparam int BUFSIZE   = MAXIMG + 1;
  localparam int BUFLINE   = MAXFIL + 1;
  localparam int SIZEWIDTH = $clog2(BUFSIZE);
  localparam int LINEWIDTH = $clog2(BUFLINE);

  logic                                        buf_wcol;
  logic [MAXFIL-1:0]                           buf_rrow;
  logic [LINEWIDTH:0]                          buf_wsel;
  logic [LINEWIDTH:0]                          buf_rsel;
  logic                                        buf_we;
  logic [SIZEWIDTH-1:0]                        buf_addr;
  logic signed [DWIDTH-1:0]                    buf_input;
  logic signed [MAXFIL*MAXFIL-1:0][DWIDTH-1:0] buf_output;

  modport master (
    output buf_wcol, buf_rrow, buf_wsel, buf_rsel, buf_we, buf_addr, buf_input,
    input  buf_output
  );
  modport slave (
    input  buf_wcol, buf_rrow, buf_wsel, buf_rsel, buf_we, buf_addr, buf_input,
    output buf_output
  );
endinterface

// File: rtl/renkon_linebuf_mem.sv
// One line of pixel storage: single port, read-first, registered read data.
module renkon_linebuf_mem #(
  parameter int DEPTH = 33,
  parameter int AW    = 6,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          xrst,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);
  logic [DW-1:0] mem [DEPTH];
  logic          in_range;

  // extra bit keeps the bound correct when DEPTH is a power of two
  assign in_range = {1'b0, addr} < (AW+1)'(DEPTH);

  always_ff @(posedge clk) begin
    if (we && in_range) mem[addr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!xrst)         dout <= '0;
    else if (in_range) dout <= mem[addr];
    else               dout <= '0;
  end
endmodule

// File: rtl/renkon_linebuf_pad.sv
// Circular line buffer with zero padding feeding a MAXFIL x MAXFIL sliding window.
module renkon_linebuf_pad
  import renkon_linebuf_pad_pkg::*;
#(
  parameter int MAXFIL = 3,
  parameter int MAXIMG = 32
) (
  input  logic                  clk,
  input  logic                  xrst,
  renkon_linebuf_pad_if.slave   bus
);
  localparam int BUFSIZE   = MAXIMG + 1;
  localparam int BUFLINE   = MAXFIL + 1;
  localparam int SIZEWIDTH = $clog2(BUFSIZE);
  localparam int LINEWIDTH = $clog2(BUFLINE);
  localparam int LW2       = LINEWIDTH + 2;

  logic [BUFLINE-1:0][DWIDTH-1:0]             rdata;
  logic [DWIDTH-1:0]                          wdata;
  logic [MAXFIL-1:0][DWIDTH-1:0]              row_in;
  logic [MAXFIL-1:0][MAXFIL-1:0][DWIDTH-1:0]  win;

  assign wdata = bus.buf_wcol ? bus.buf_input : '0;

  for (genvar k = 0; k < BUFLINE; k++) begin : g_line
    logic we_k;
    // lines are numbered from 1; select 0 or beyond BUFLINE matches nothing
    assign we_k = xrst && bus.buf_we && (bus.buf_wsel == (LINEWIDTH+1)'(k + 1));
    renkon_linebuf_mem #(.DEPTH(BUFSIZE), .AW(SIZEWIDTH), .DW(DWIDTH)) u_mem (
      .clk  (clk),
      .xrst (xrst),
      .we   (we_k),
      .addr (bus.buf_addr),
      .din  (wdata),
      .dout (rdata[k])
    );
  end

  for (genvar j = 0; j < MAXFIL; j++) begin : g_row
    logic [LW2-1:0]       lsum;
    logic [LINEWIDTH-1:0] lidx;
    // zero-based line index: (rsel - 1 + j) mod BUFLINE
    assign lsum      = LW2'(bus.buf_rsel) + LW2'(j) - LW2'(1);
    assign lidx      = LINEWIDTH'(lsum % LW2'(BUFLINE));
    assign row_in[j] = (bus.buf_rrow[j] && (bus.buf_rsel != '0)) ? rdata[lidx] : '0;
  end

  always_ff @(posedge clk) begin
    if (!xrst) begin
      win <= '0;
    end else begin
      for (int r = 0; r < MAXFIL; r++) begin
        for (int c = 0; c < MAXFIL - 1; c++) win[r][c] <= win[r][c+1];
        win[r][MAXFIL-1] <= row_in[r];
      end
    end
  end

  assign bus.buf_output = win;
endmodule

// File: tb/tb_renkon_linebuf_pad.sv
// Directed table plus randomized run against a queue-based window model.
module tb_renkon_linebuf_pad;
  localparam int MAXFIL = 3;
  localparam int MAXIMG = 32;
  localparam int BUFSIZE = MAXIMG + 1;
  localparam int BUFLINE = MAXFIL + 1;
  localparam int DW = 16;

  typedef logic [MAXFIL*MAXFIL-1:0][DW-1:0] win_t;
  typedef logic [MAXFIL-1:0][DW-1:0]        rowv_t;
  typedef struct {
    bit          rst_n, we, wcol;
    logic [2:0]  wsel, rsel, rrow;
    logic [5:0]  addr;
    logic [15:0] din;
    bit          chk;
    win_t        exp;
  } vec_t;

  logic clk = 1'b0;
  logic xrst;
  int   vectors = 0;
  int   miscompares = 0;

  renkon_linebuf_pad_if #(.MAXFIL(MAXFIL), .MAXIMG(MAXIMG)) bus ();
  renkon_linebuf_pad #(.MAXFIL(MAXFIL), .MAXIMG(MAXIMG)) dut (
    .clk  (clk),
    .xrst (xrst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // reference state: memory contents, last read data, history of row values entering the window
  logic [15:0] mm   [BUFLINE][BUFSIZE];
  logic [15:0] rd_m [BUFLINE];
  rowv_t       q[$];

  function automatic vec_t v(bit rn, bit we, bit wc, int ws, int rs, int rr, int ad, int di,
                             bit ck = 0, win_t ex = '0);
    vec_t t;
    t.rst_n = rn; t.we = we; t.wcol = wc;
    t.wsel = 3'(ws); t.rsel = 3'(rs); t.rrow = 3'(rr);
    t.addr = 6'(ad); t.din = 16'(di); t.chk = ck; t.exp = ex;
    return t;
  endfunction

  // args in output order: row0 col0..col2, row1 ..., row2 ...
  function automatic win_t w9(int a0, int a1, int a2, int a3, int a4, int a5, int a6, int a7, int a8);
    win_t w;
    w[0] = 16'(a0); w[1] = 16'(a1); w[2] = 16'(a2);
    w[3] = 16'(a3); w[4] = 16'(a4); w[5] = 16'(a5);
    w[6] = 16'(a6); w[7] = 16'(a7); w[8] = 16'(a8);
    return w;
  endfunction

  task automatic model(input vec_t t);
    logic [15:0] rd_new [BUFLINE];
    rowv_t nv;
    if (!t.rst_n) begin
      for (int l = 0; l < BUFLINE; l++) rd_m[l] = '0;
      for (int i = 0; i < MAXFIL; i++) q.push_back('0);
    end else begin
      for (int j = 0; j < MAXFIL; j++) begin
        nv[j] = '0;
        if (t.rrow[j] && t.rsel != 0) nv[j] = rd_m[(int'(t.rsel) - 1 + j) % BUFLINE];
      end
      q.push_back(nv);
      for (int l = 0; l < BUFLINE; l++)
        rd_new[l] = (int'(t.addr) < BUFSIZE) ? mm[l][t.addr] : '0;
      if (t.we && t.wsel >= 1 && int'(t.wsel) <= BUFLINE && int'(t.addr) < BUFSIZE)
        mm[t.wsel - 1][t.addr] = t.wcol ? t.din : '0;
      for (int l = 0; l < BUFLINE; l++) rd_m[l] = rd_new[l];
    end
    while (q.size() > MAXFIL) void'(q.pop_front());
  endtask

  function automatic win_t exp_model();
    win_t w;
    int n = q.size();
    for (int r = 0; r < MAXFIL; r++)
      for (int c = 0; c < MAXFIL; c++) w[r*MAXFIL + c] = q[n - MAXFIL + c][r];
    return w;
  endfunction

  task automatic chk(input string nm, input win_t act, input win_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input vec_t t);
    xrst          = t.rst_n;
    bus.buf_we    = t.we;
    bus.buf_wcol  = t.wcol;
    bus.buf_wsel  = t.wsel;
    bus.buf_rsel  = t.rsel;
    bus.buf_rrow  = t.rrow;
    bus.buf_addr  = t.addr;
    bus.buf_input = t.din;
    model(t);
    @(posedge clk);
    #1;
    chk("model", bus.buf_output, exp_model());
  endtask

  vec_t tv[$];

  initial begin
    for (int i = 0; i < MAXFIL; i++) q.push_back('0);

    // reset with junk on the bus: window must read zero
    for (int i = 0; i < 3; i++) step(v(0, 1, 1, 1, 1, 7, i, 100 + i));
    chk("reset", bus.buf_output, '0);

    // memory is undefined after reset, so give every word a known zero
    for (int l = 1; l <= BUFLINE; l++)
      for (int a = 0; a < BUFSIZE; a++) step(v(1, 1, 0, l, 0, 0, a, 5));

    // write 1..5 into line 1, then stream it out through row 0
    for (int i = 0; i < 5; i++) tv.push_back(v(1, 1, 1, 1, 0, 0, i, i + 1, 1, '0));
    for (int i = 0; i < 6; i++)
      tv.push_back(v(1, 0, 0, 0, 1, 7, i, 0, 1,
                     w9((i > 2) ? i - 2 : 0, (i > 1) ? i - 1 : 0, i, 0, 0, 0, 0, 0, 0)));
    tv.push_back(v(1, 1, 1, 2, 0, 0, 3, 9));
    tv.push_back(v(1, 1, 1, 4, 0, 0, 0, 40));
    tv.push_back(v(1, 1, 1, 2, 0, 0, 0, 20));
    tv.push_back(v(1, 1, 1, 3, 0, 0, 0, 30));
    tv.push_back(v(1, 1, 0, 2, 0, 0, 5, 7));  // pad write: stores zero
    // rsel=4 wraps: rows from lines 4,1,2
    for (int i = 0; i < 4; i++)
      tv.push_back(v(1, 0, 0, 0, 4, 7, 0, 0, i == 3, w9(40, 40, 40, 1, 1, 1, 20, 20, 20)));
    // only row 1 enabled
    for (int i = 0; i < 4; i++)
      tv.push_back(v(1, 0, 0, 0, 1, 2, 0, 0, i == 3, w9(0, 0, 0, 20, 20, 20, 0, 0, 0)));
    // padded pixel reads back zero behind a real 20
    for (int i = 0; i < 4; i++)
      tv.push_back(v(1, 0, 0, 0, 2, 1, 5, 0, i >= 2,
                     (i == 2) ? w9(20, 0, 0, 0, 0, 0, 0, 0, 0) : '0));
    // read-first on same line/address
    tv.push_back(v(1, 1, 1, 2, 2, 1, 3, 6, 1, '0));
    tv.push_back(v(1, 0, 0, 0, 2, 1, 3, 0, 1, w9(0, 0, 9, 0, 0, 0, 0, 0, 0)));
    tv.push_back(v(1, 0, 0, 0, 2, 1, 3, 0, 1, w9(0, 9, 6, 0, 0, 0, 0, 0, 0)));
    // stream, then a one-cycle reset with a write attempt
    tv.push_back(v(1, 0, 0, 0, 1, 7, 0, 0, 1, w9(9, 6, 4, 0, 0, 6, 0, 0, 0)));
    tv.push_back(v(1, 0, 0, 0, 1, 7, 0, 0, 1, w9(6, 4, 1, 0, 6, 20, 0, 0, 30)));
    tv.push_back(v(1, 0, 0, 0, 1, 7, 0, 0, 1, w9(4, 1, 1, 6, 20, 20, 0, 30, 30)));
    tv.push_back(v(0, 1, 1, 1, 1, 7, 0, 99, 1, '0));
    tv.push_back(v(1, 0, 0, 0, 1, 7, 0, 0, 1, '0));
    tv.push_back(v(1, 0, 0, 0, 1, 7, 0, 0, 1, w9(0, 0, 1, 0, 0, 20, 0, 0, 30)));
    // out-of-range select and address writes are dropped
    tv.push_back(v(1, 1, 1, 5, 0, 0, 0, 77));
    tv.push_back(v(1, 1, 1, 1, 0, 0, 40, 55));
    for (int i = 0; i < 4; i++)
      tv.push_back(v(1, 0, 0, 0, 1, 7, 0, 0, i == 3, w9(1, 1, 1, 20, 20, 20, 30, 30, 30)));
    for (int i = 0; i < 4; i++)
      tv.push_back(v(1, 0, 0, 0, 1, 7, 40, 0, i == 3, '0));

    foreach (tv[i]) begin
      step(tv[i]);
      if (tv[i].chk) chk($sformatf("tbl%0d", i), bus.buf_output, tv[i].exp);
    end

    for (int i = 0; i < 800; i++) begin
      int ad = ($urandom_range(9, 0) == 0) ? $urandom_range(63, 33) : $urandom_range(7, 0);
      step(v(($urandom_range(49, 0) != 0), $urandom_range(1, 0), ($urandom_range(3, 0) != 0),
             $urandom_range(7, 0), $urandom_range(BUFLINE, 0), $urandom_range(7, 0),
             ad, $urandom_range(65535, 0)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
